// File: rtl/uart_rom_tx_if.sv
// rtl/uart_rom_tx_if.sv - ROM-fetch / serial-line bundle for the UART ROM transmitter.
// master: transmitter side; slave: ROM, pin and requester side.
interface uart_rom_tx_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] rom_data;
    logic [3:0]       rom_addr;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        input  start,
        input  rom_data,
        output rom_addr,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output rom_data,
        input  rom_addr,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/uart_rom_tx.sv
// rtl/uart_rom_tx.sv - walks ROM entries 0..MSG_LEN-1 and sends each low byte as a UART frame.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_rom_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int MSG_LEN      = 16
) (
    input  logic          CLOCK,
    input  logic          RESET,
    uart_rom_tx_if.master bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_ADDR = 4'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       addr_q, addr_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic bit_end;
    logic in_bit_state;
    logic unused_rom_hi;

    assign bit_end       = (cnt_q == CNT_MAX);
    assign unused_rom_hi = ^bus.rom_data;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        in_bit_state = 1'b0;
        case (state_q)
            S_START, S_DATA, S_STOP: in_bit_state = 1'b1;
`ifdef UART_TX_PARITY_EN
            S_PARITY:                in_bit_state = 1'b1;
`endif
            default:                 in_bit_state = 1'b0;
        endcase
    end

    // tx_d always carries the level for the next cycle, so tx is a pure flop output.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (in_bit_state && !bit_end) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (bus.start) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = bus.rom_data[7:0];
`ifdef UART_TX_PARITY_EN
                par_d   = ^bus.rom_data[7:0];
`endif
                tx_d    = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = 4'd0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rom_addr = addr_q;
endmodule

// File: tb/tb_uart_rom_tx.sv
// tb/tb_uart_rom_tx.sv - directed bench for uart_rom_tx (honours UART_TX_PARITY_EN).
module tb_uart_rom_tx;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB  = 11;
    localparam int T1  = 47;
    localparam int T16 = 737;
    localparam logic [10:0] F_A9 = 11'h552;
    localparam logic [10:0] F_A8 = 11'h750;
`else
    localparam int FB  = 10;
    localparam int T1  = 43;
    localparam int T16 = 673;
    localparam logic [10:0] F_A9 = 11'h352;
    localparam logic [10:0] F_A8 = 11'h350;
`endif
    localparam int CHAR = 2 + FB * C;

    logic       clk = 1'b0;
    logic       rst1, rst16;
    logic [7:0] rom1_0;
    int         checks, failures;
    int         done_at, done_cnt;
    logic       tx_log   [0:1023];
    logic       busy_log [0:1023];
    logic [3:0] addr_log [0:1023];

    always #5 clk = ~clk;

    uart_rom_tx_if #(.WIDTH(8)) b1 ();
    uart_rom_tx_if #(.WIDTH(8)) b16 ();

    uart_rom_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .MSG_LEN(1)) u1 (
        .CLOCK (clk),
        .RESET (rst1),
        .bus   (b1)
    );
    uart_rom_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .MSG_LEN(16)) u16 (
        .CLOCK (clk),
        .RESET (rst16),
        .bus   (b16)
    );

    always @(posedge clk) b1.rom_data  <= (b1.rom_addr == 4'd0) ? rom1_0 : 8'h00;
    always @(posedge clk) b16.rom_data <= (b16.rom_addr == 4'd5) ? 8'hA8 : 8'hA9;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 1) b1.start = v;
        else            b16.start = v;
    endtask

    // Pulses start, then logs one sample per cycle (cycle 1 = first cycle after the start edge).
    task automatic run(input int which, input int maxc, input int restart_at);
        logic d;
        done_at  = 0;
        done_cnt = 0;
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        for (int c = 1; c <= maxc; c++) begin
            if (which == 1) begin
                tx_log[c] = b1.tx;  busy_log[c] = b1.busy;  addr_log[c] = b1.rom_addr;  d = b1.done;
            end else begin
                tx_log[c] = b16.tx; busy_log[c] = b16.busy; addr_log[c] = b16.rom_addr; d = b16.done;
            end
            set_start(which, c == restart_at);
            if (d) begin
                done_cnt++;
                done_at = c;
                set_start(which, 1'b0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_char(input string tag, input int k, input logic [10:0] exp);
        logic [10:0] f;
        logic        stable;
        int          w;
        f      = '0;
        stable = 1'b1;
        for (int b = 0; b < FB; b++) begin
            w    = 3 + k * CHAR + b * C;
            f[b] = tx_log[w + 2];
            for (int i = 0; i < C; i++) if (tx_log[w + i] !== tx_log[w]) stable = 1'b0;
        end
        chk({tag, "_frame"}, {20'd0, stable, f}, {20'd0, 1'b1, exp});
        chk({tag, "_gap"}, {30'd0, tx_log[1 + k * CHAR], tx_log[2 + k * CHAR]}, 32'd3);
        chk({tag, "_addr"}, {28'd0, addr_log[1 + k * CHAR]}, k);
        chk({tag, "_addr_hold"}, {28'd0, addr_log[k * CHAR + CHAR]}, k);
    endtask

    initial begin
        int extra;
        checks   = 0;
        failures = 0;
        b1.start  = 1'b0;
        b16.start = 1'b0;
        rom1_0    = 8'hA9;
        rst1      = 1'b1;
        rst16     = 1'b1;
        repeat (3) @(negedge clk);
        rst1  = 1'b0;
        rst16 = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle1",  {25'd0, b1.tx,  b1.busy,  b1.done,  b1.rom_addr},  32'h40);
            chk("idle16", {25'd0, b16.tx, b16.busy, b16.done, b16.rom_addr}, 32'h40);
        end

        run(1, 200, 0);
        chk("single_done_at", done_at, T1);
        chk("single_busy_first", {31'd0, busy_log[1]}, 32'd1);
        chk("single_busy_last", {31'd0, busy_log[T1 - 1]}, 32'd1);
        chk("single_end_state", {27'd0, b1.busy, b1.rom_addr}, 32'd0);
        check_char("single", 0, F_A9);

        run(1, 200, 0);
        chk("b2b_done_at", done_at, T1);
        check_char("b2b", 0, F_A9);

        repeat (5) @(negedge clk);
        run(1, 200, 20);
        chk("busy_start_done_at", done_at, T1);
        check_char("busy_start", 0, F_A9);
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b1.done !== 1'b0 || b1.busy !== 1'b0) extra++;
        end
        chk("busy_start_quiet", extra, 0);

        run(16, 1000, 0);
        chk("full_done_at", done_at, T16);
        chk("full_end_state", {27'd0, b16.busy, b16.rom_addr}, 32'd0);
        for (int k = 0; k < 16; k++)
            check_char($sformatf("full%0d", k), k, (k == 5) ? F_A8 : F_A9);
        @(negedge clk);
        chk("full_done_width", {31'd0, b16.done}, 32'd0);

        repeat (3) @(negedge clk);
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_reset_bit3", {31'd0, b1.tx}, 32'd1);
        rst1 = 1'b1;
        @(negedge clk);
        chk("reset_mid", {25'd0, b1.tx, b1.busy, b1.done, b1.rom_addr}, 32'h40);
        rst1  = 1'b0;
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b1.done !== 1'b0 || b1.tx !== 1'b1) extra++;
        end
        chk("reset_quiet", extra, 0);
        run(1, 200, 0);
        chk("after_reset_done_at", done_at, T1);
        check_char("after_reset", 0, F_A9);

        rom1_0 = 8'hA8;
        @(negedge clk);
        run(1, 200, 0);
        chk("a8_done_at", done_at, T1);
        check_char("a8", 0, F_A8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
